score_overlay_renderer: RTL and testbench



---
 rtl/score_overlay_renderer.sv | 228 ++++++++++++++++++++++
 tb/tb_score_overlay_renderer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_overlay_renderer.sv
// Score overlay renderer: maps the VGA pixel stream onto a per-frame snapshot of the 3-digit glyph bitmap.
// Optional SCORE_LEAD_ZERO_BLANK_EN blanks leading zero digits (hundreds, then tens).
module score_overlay_renderer #(
  parameter logic [9:0] X0           = 10'd8,
  parameter logic [8:0] Y0           = 9'd8,
  parameter int         SCALE_LOG2   = 1,
  parameter int         FLASH_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [89:0] score_display,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic        ovl_valid,
  output logic        ovl_on
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [10:0] BOX_W = 11'(18 << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(5 << SCALE_LOG2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((FLASH_FRAMES > 0) ? (FLASH_FRAMES - 1) : 0);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STEADY = 2'd1,
    ST_FLASH  = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             phase_r, phase_nx_s;
  logic             visible_s;
  logic             changed_s;
  logic [89:0]      snap_r;

  logic [10:0] dx_s, dy_s;
  logic        in_box_s;
  logic        s1_valid_r, s1_in_box_r;
  logic [4:0]  s1_gcol_r;
  logic [2:0]  s1_grow_r;

  logic [1:0]  digit_s;
  logic [2:0]  col_s;
  logic [29:0] digit_bits_s;
  logic [5:0]  row_bits_s;
  logic        lit_s;
  logic        blank_s;
  logic        blank_h_s, blank_t_s;

  assign changed_s = (score_display != snap_r);

  // Stage 1 geometry: 11-bit offsets so a pixel left of / above the box shows up in the sign bit
  always_comb begin
    dx_s     = {1'b0, pix_x} - {1'b0, X0};
    dy_s     = {2'b00, pix_y} - {2'b00, Y0};
    in_box_s = pix_valid & ~dx_s[10] & ~dy_s[10] & (dx_s < BOX_W) & (dy_s < BOX_H);
  end

  // Stage 1 pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_in_box_r <= 1'b0;
      s1_gcol_r   <= 5'd0;
      s1_grow_r   <= 3'd0;
    end else begin
      s1_valid_r  <= pix_valid;
      s1_in_box_r <= in_box_s;
      s1_gcol_r   <= 5'(dx_s >> SCALE_LOG2);
      s1_grow_r   <= 3'(dy_s >> SCALE_LOG2);
    end
  end

  // Stage 2 glyph lookup: digit select by range compare, then row and column bit pick
  always_comb begin
    if (s1_gcol_r < 5'd6) begin
      digit_s = 2'd0;
      col_s   = 3'(s1_gcol_r);
    end else if (s1_gcol_r < 5'd12) begin
      digit_s = 2'd1;
      col_s   = 3'(s1_gcol_r - 5'd6);
    end else begin
      digit_s = 2'd2;
      col_s   = 3'(s1_gcol_r - 5'd12);
    end

    case (digit_s)
      2'd0:    begin digit_bits_s = snap_r[89:60]; blank_s = blank_h_s; end
      2'd1:    begin digit_bits_s = snap_r[59:30]; blank_s = blank_t_s; end
      default: begin digit_bits_s = snap_r[29:0];  blank_s = 1'b0;      end
    endcase

    case (s1_grow_r)
      3'd0:    row_bits_s = digit_bits_s[5:0];
      3'd1:    row_bits_s = digit_bits_s[11:6];
      3'd2:    row_bits_s = digit_bits_s[17:12];
      3'd3:    row_bits_s = digit_bits_s[23:18];
      3'd4:    row_bits_s = digit_bits_s[29:24];
      default: row_bits_s = 6'd0;
    endcase

    if (col_s <= 3'd5) begin
      lit_s = row_bits_s[3'd5 - col_s];
    end else begin
      lit_s = 1'b0;
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ovl_valid <= 1'b0;
      ovl_on    <= 1'b0;
    end else begin
      ovl_valid <= s1_valid_r;
      ovl_on    <= s1_in_box_r & lit_s & visible_s & ~blank_s;
    end
  end

  // Frame snapshot: only refreshed at frame_start so a frame never mixes two scores
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r <= 90'd0;
    end else if (frame_start) begin
      snap_r <= score_display;
    end else begin
      snap_r <= snap_r;
    end
  end

`ifdef SCORE_LEAD_ZERO_BLANK_EN
  localparam logic [29:0] ZERO_GLYPH = {6'b001100, 6'b011010, 6'b010110, 6'b010010, 6'b001100};

  function automatic logic is_zero_glyph(input logic [29:0] glyph);
    return (glyph == ZERO_GLYPH);
  endfunction

  logic blank_h_r, blank_t_r;

  // Blank flags track the value being loaded into snap so they stay aligned with it
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_h_r <= 1'b0;
      blank_t_r <= 1'b0;
    end else if (frame_start) begin
      blank_h_r <= is_zero_glyph(score_display[89:60]);
      blank_t_r <= is_zero_glyph(score_display[89:60]) & is_zero_glyph(score_display[59:30]);
    end else begin
      blank_h_r <= blank_h_r;
      blank_t_r <= blank_t_r;
    end
  end

  assign blank_h_s = blank_h_r;
  assign blank_t_s = blank_t_r;
`else
  assign blank_h_s = 1'b0;
  assign blank_t_s = 1'b0;
`endif

  // Flash FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      phase_r <= phase_nx_s;
    end
  end

  // Flash FSM next state: decisions are taken only on frame_start
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    phase_nx_s = phase_r;
    if (frame_start) begin
      case (state_r)
        ST_INIT: begin
          state_nx_s = ST_STEADY;
          cnt_nx_s   = '0;
          phase_nx_s = 1'b0;
        end
        ST_STEADY: begin
          if (changed_s && (FLASH_FRAMES > 0)) begin
            state_nx_s = ST_FLASH;
            cnt_nx_s   = CNT_INIT;
            phase_nx_s = 1'b0;
          end else begin
            state_nx_s = ST_STEADY;
          end
        end
        ST_FLASH: begin
          if (changed_s) begin
            cnt_nx_s   = CNT_INIT;
            phase_nx_s = 1'b0;
          end else if (cnt_r == '0) begin
            state_nx_s = ST_STEADY;
            phase_nx_s = 1'b0;
          end else begin
            phase_nx_s = ~phase_r;
            cnt_nx_s   = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nx_s = ST_INIT;
          cnt_nx_s   = '0;
          phase_nx_s = 1'b0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Flash FSM output: dark on even flash phases
  always_comb begin
    case (state_r)
      ST_FLASH: visible_s = phase_r;
      default:  visible_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_score_overlay_renderer.sv
// Directed bench for score_overlay_renderer: table-driven pixel checks plus frame/flash/reset sequences.
module tb_score_overlay_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [89:0] score_display = 90'd0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = 10'd0;
  logic [8:0]  pix_y = 9'd0;
  logic        ovl_valid;
  logic        ovl_on;

  int checks = 0;
  int errors = 0;

  localparam logic [29:0] G0 = {6'b001100, 6'b011010, 6'b010110, 6'b010010, 6'b001100};
  localparam logic [29:0] G8 = {6'b011110, 6'b010010, 6'b011110, 6'b010010, 6'b011110};
  localparam logic [29:0] G7 = {6'b001000, 6'b001000, 6'b000100, 6'b000010, 6'b111110};

`ifdef SCORE_LEAD_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       exp;
  } vec_t;

  vec_t vecs[14];

  score_overlay_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .score_display(score_display),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .ovl_valid    (ovl_valid),
    .ovl_on       (ovl_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic act, input logic exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic check_pixel(input logic [9:0] x, input logic [8:0] y, input logic exp, input string name);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x     = x;
    pix_y     = y;
    @(negedge clk);
    pix_valid = 1'b0;
    chk(ovl_valid, 1'b0, {name, "_lat1"});
    @(negedge clk);
    chk(ovl_valid, 1'b1, {name, "_valid"});
    chk(ovl_on, exp, name);
  endtask

  task automatic frame(input logic [89:0] v);
    @(negedge clk);
    score_display = v;
    frame_start   = 1'b1;
    @(negedge clk);
    frame_start   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Box-edge and digit-boundary vectors against "888"
    vecs[0]  = '{10'd7,  9'd8,  1'b0};
    vecs[1]  = '{10'd44, 9'd9,  1'b0};
    vecs[2]  = '{10'd12, 9'd17, 1'b1};
    vecs[3]  = '{10'd12, 9'd18, 1'b0};
    vecs[4]  = '{10'd8,  9'd8,  1'b0};
    vecs[5]  = '{10'd10, 9'd8,  1'b1};
    vecs[6]  = '{10'd43, 9'd17, 1'b0};
    vecs[7]  = '{10'd41, 9'd8,  1'b1};
    vecs[8]  = '{10'd10, 9'd12, 1'b1};
    vecs[9]  = '{10'd12, 9'd10, 1'b0};
    vecs[10] = '{10'd20, 9'd8,  1'b0};
    vecs[11] = '{10'd22, 9'd8,  1'b1};
    vecs[12] = '{10'd32, 9'd8,  1'b0};
    vecs[13] = '{10'd34, 9'd7,  1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk(ovl_valid, 1'b0, "rst_valid");
    chk(ovl_on, 1'b0, "rst_on");
    check_pixel(10'd12, 9'd8, 1'b0, "init_snap_zero");

    frame({G0, G0, G0});
    check_pixel(10'd8,  9'd8, 1'b0, "z_c0");
    check_pixel(10'd12, 9'd8, 1'b1, "z_c2");

    // Score change: dark, lit, dark, lit, then steady
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b0, "fl_f0");
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b1, "fl_f1");
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b0, "fl_f2");
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b1, "fl_f3");
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b1, "fl_f4");
    frame({G8, G8, G8}); check_pixel(10'd10, 9'd8, 1'b1, "fl_f5");

    for (int i = 0; i < 14; i++) begin
      check_pixel(vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Mid-frame change is ignored until frame_start
    @(negedge clk);
    score_display = {G7, G7, G7};
    check_pixel(10'd8, 9'd8, 1'b0, "midframe_hold");
    frame({G7, G7, G7}); check_pixel(10'd8,  9'd8,  1'b0, "n7_f0");
    frame({G7, G7, G7}); check_pixel(10'd8,  9'd8,  1'b1, "n7_f1");
    check_pixel(10'd12, 9'd17, 1'b1, "n7_r4c2");
    check_pixel(10'd10, 9'd17, 1'b0, "n7_r4c1");
    // Change during flash restarts the sequence
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b0, "rs_f0");
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b1, "rs_f1");
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b0, "rs_f2");
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b1, "rs_f3");
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b1, "rs_f4");
    frame({G0, G0, G0}); check_pixel(10'd12, 9'd8, 1'b1, "rs_f5");

    // Reset while streaming lit pixels
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x     = 10'd12;
    pix_y     = 9'd8;
    repeat (3) @(negedge clk);
    chk(ovl_valid, 1'b1, "stream_valid");
    chk(ovl_on, 1'b1, "stream_on");
    reset = 1'b1;
    @(negedge clk);
    chk(ovl_valid, 1'b0, "midrst_valid");
    chk(ovl_on, 1'b0, "midrst_on");
    reset     = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk(ovl_valid, 1'b0, "postrst_valid");
    frame({G8, G8, G8});
    check_pixel(10'd10, 9'd8, 1'b1, "postrst_noflash");

    // Leading-zero handling
    do_reset();
    frame({G0, G0, G7});
    check_pixel(10'd12, 9'd8, ~LZ, "lz007_hund");
    check_pixel(10'd24, 9'd8, ~LZ, "lz007_tens");
    check_pixel(10'd32, 9'd8, 1'b1, "lz007_unit");
    do_reset();
    frame({G0, G7, G0});
    check_pixel(10'd12, 9'd8, ~LZ, "lz070_hund");
    check_pixel(10'd20, 9'd8, 1'b1, "lz070_tens");
    check_pixel(10'd36, 9'd8, 1'b1, "lz070_unit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
